ulpb_lc_rx_fifo: RTL and testbench

ULPB_LC_RX_FIFO -- requirements
Module: ulpb_lc_rx_fifo

---
 rtl/ulpb_lc_rx_fifo.sv | 110 +++++++++++
 tb/tb_ulpb_lc_rx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_lc_rx_fifo.sv
// Link-controller receive FIFO: REQ/ACK handshake into a DEPTH-entry queue with a valid/ready read port.
// Optional ULPB_RX_DROP_EN: acknowledge and discard requests arriving while full, counted on DROP_CNT.
module ulpb_lc_rx_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_IN,
  input  logic [ADDR_WIDTH-1:0]   ADDR_IN,
  input  logic [DATA_WIDTH-1:0]   DATA_IN,
  output logic                    ACK_OUT,
  output logic                    RD_VALID,
  output logic [ADDR_WIDTH-1:0]   RD_ADDR,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  input  logic                    RD_READY,
  output logic [$clog2(DEPTH):0]  COUNT
`ifdef ULPB_RX_DROP_EN
  ,
  output logic [7:0]              DROP_CNT
`endif
);

  // state | meaning
  // IDLE  | waiting for a REQ_IN high phase, ACK_OUT low
  // ACKED | message taken (or dropped), ACK_OUT high until REQ_IN falls
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACKED = 1'b1;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [0:0]    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_accept;

  // Full is judged on the pre-edge count, so a same-edge pop never frees room for a push.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_push   = (r_state == ST_IDLE) && REQ_IN && !w_full;
  assign w_pop    = (r_count != '0) && RD_READY;
`ifdef ULPB_RX_DROP_EN
  assign w_drop   = (r_state == ST_IDLE) && REQ_IN && w_full;
`else
  assign w_drop   = 1'b0;
`endif
  assign w_accept = w_push || w_drop;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_ACKED;
        ST_ACKED: if (!REQ_IN)  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; the head is only meaningful while RD_VALID is high.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {ADDR_IN, DATA_IN};
  end

`ifdef ULPB_RX_DROP_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign DROP_CNT = r_drop_cnt;
`endif

  assign ACK_OUT            = (r_state == ST_ACKED);
  assign RD_VALID           = (r_count != '0);
  assign {RD_ADDR, RD_DATA} = r_mem[r_rd_ptr];
  assign COUNT              = r_count;

endmodule

// File: tb/tb_ulpb_lc_rx_fifo.sv
// Directed bench for ulpb_lc_rx_fifo; the drop scenario runs when ULPB_RX_DROP_EN is defined.
module tb_ulpb_lc_rx_fifo;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ_IN = 1'b0;
  logic [7:0]  ADDR_IN = '0;
  logic [31:0] DATA_IN = '0;
  logic        ACK_OUT;
  logic        RD_VALID;
  logic [7:0]  RD_ADDR;
  logic [31:0] RD_DATA;
  logic        RD_READY = 1'b0;
  logic [2:0]  COUNT;
`ifdef ULPB_RX_DROP_EN
  logic [7:0]  DROP_CNT;
`endif

  int total = 0;
  int bad   = 0;

  ulpb_lc_rx_fifo #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ_IN   (REQ_IN),
    .ADDR_IN  (ADDR_IN),
    .DATA_IN  (DATA_IN),
    .ACK_OUT  (ACK_OUT),
    .RD_VALID (RD_VALID),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (RD_DATA),
    .RD_READY (RD_READY),
    .COUNT    (COUNT)
`ifdef ULPB_RX_DROP_EN
    ,
    .DROP_CNT (DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] msg_data(input int k);
    return {4{8'(k)}};
  endfunction

  // Drive message k, wait (bounded) for ACK, then drop REQ_IN for the release edge.
  task automatic send(input int k);
    bit acked = 1'b0;
    REQ_IN  = 1'b1;
    ADDR_IN = 8'(k);
    DATA_IN = msg_data(k);
    for (int i = 0; i < 20 && !acked; i++) begin
      step();
      acked = ACK_OUT;
    end
    total++;
    if (!acked) begin
      bad++;
      $display("FAIL send_ack msg %0d: ack=%b want 1", k, ACK_OUT);
    end
    REQ_IN = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #23;
    total++;
    if ({ACK_OUT, RD_VALID, COUNT} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: ack=%b valid=%b count=%0d want 0 0 0", ACK_OUT, RD_VALID, COUNT);
    end
`ifdef ULPB_RX_DROP_EN
    total++;
    if (DROP_CNT !== 8'd0) begin
      bad++;
      $display("FAIL reset_drop_cnt: got %0d want 0", DROP_CNT);
    end
`endif
    RESET = 1'b1;
    step();
  endtask

  task automatic test_single();
    REQ_IN  = 1'b1;
    ADDR_IN = 8'hAB;
    DATA_IN = 32'h12345678;
    step();
    total++;
    if ({ACK_OUT, RD_VALID, COUNT, RD_ADDR, RD_DATA} !== {1'b1, 1'b1, 3'd1, 8'hAB, 32'h12345678}) begin
      bad++;
      $display("FAIL single_write: ack=%b valid=%b count=%0d addr=%h data=%h want 1 1 1 ab 12345678",
               ACK_OUT, RD_VALID, COUNT, RD_ADDR, RD_DATA);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) step();
    total++;
    if ({ACK_OUT, COUNT} !== {1'b1, 3'd1}) begin
      bad++;
      $display("FAIL hold_one_write: ack=%b count=%0d want 1 1", ACK_OUT, COUNT);
    end
    REQ_IN = 1'b0;
    step();
    total++;
    if (ACK_OUT !== 1'b0) begin
      bad++;
      $display("FAIL ack_release: ack=%b want 0", ACK_OUT);
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== 4'b0) begin
      bad++;
      $display("FAIL pop_single: valid=%b count=%0d want 0 0", RD_VALID, COUNT);
    end
    // Ready with nothing queued must not disturb the count.
    RD_READY = 1'b1;
    step();
    step();
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== 4'b0) begin
      bad++;
      $display("FAIL ready_when_empty: valid=%b count=%0d want 0 0", RD_VALID, COUNT);
    end
  endtask

`ifndef ULPB_RX_DROP_EN
  task automatic test_full_backpressure();
    RD_READY = 1'b0;
    for (int k = 1; k <= 4; k++) send(k);
    total++;
    if (COUNT !== 3'd4) begin
      bad++;
      $display("FAIL fill_count: got %0d want 4", COUNT);
    end
    REQ_IN  = 1'b1;
    ADDR_IN = 8'd5;
    DATA_IN = msg_data(5);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ACK_OUT, COUNT} !== {1'b0, 3'd4}) begin
        bad++;
        $display("FAIL backpressure cyc%0d: ack=%b count=%0d want 0 4", i, ACK_OUT, COUNT);
      end
    end
    total++;
    if ({RD_ADDR, RD_DATA} !== {8'd1, msg_data(1)}) begin
      bad++;
      $display("FAIL head_first: addr=%h data=%h want 01 %h", RD_ADDR, RD_DATA, msg_data(1));
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    total++;
    if ({ACK_OUT, COUNT} !== {1'b0, 3'd3}) begin
      bad++;
      $display("FAIL pop_while_full: ack=%b count=%0d want 0 3", ACK_OUT, COUNT);
    end
    step();
    total++;
    if ({ACK_OUT, COUNT} !== {1'b1, 3'd4}) begin
      bad++;
      $display("FAIL fifth_accept: ack=%b count=%0d want 1 4", ACK_OUT, COUNT);
    end
    REQ_IN = 1'b0;
    step();
    RD_READY = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      total++;
      if ({RD_VALID, RD_ADDR, RD_DATA} !== {1'b1, 8'(k), msg_data(k)}) begin
        bad++;
        $display("FAIL order msg%0d: valid=%b addr=%h data=%h", k, RD_VALID, RD_ADDR, RD_DATA);
      end
      step();
    end
    RD_READY = 1'b0;
    total++;
    if (COUNT !== 3'd0) begin
      bad++;
      $display("FAIL drain_count: got %0d want 0", COUNT);
    end
  endtask
`endif

  task automatic test_back_to_back();
    send(8'h21);
    send(8'h22);
    REQ_IN   = 1'b1;
    ADDR_IN  = 8'h23;
    DATA_IN  = msg_data(8'h23);
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    REQ_IN   = 1'b0;
    total++;
    if ({ACK_OUT, COUNT, RD_DATA} !== {1'b1, 3'd2, msg_data(8'h22)}) begin
      bad++;
      $display("FAIL push_pop_same_edge: ack=%b count=%0d data=%h want 1 2 %h",
               ACK_OUT, COUNT, RD_DATA, msg_data(8'h22));
    end
    step();
    RD_READY = 1'b1;
    step();
    total++;
    if (RD_DATA !== msg_data(8'h23)) begin
      bad++;
      $display("FAIL push_pop_order: data=%h want %h", RD_DATA, msg_data(8'h23));
    end
    step();
    for (int k = 0; k < 10; k++) begin
      REQ_IN  = 1'b1;
      ADDR_IN = 8'(k);
      DATA_IN = 32'(k);
      step();
      total++;
      if ({RD_VALID, RD_ADDR, RD_DATA} !== {1'b1, 8'(k), 32'(k)}) begin
        bad++;
        $display("FAIL wrap_data %0d: valid=%b addr=%h data=%h", k, RD_VALID, RD_ADDR, RD_DATA);
      end
      REQ_IN = 1'b0;
      step();
    end
    RD_READY = 1'b0;
    total++;
    if (COUNT !== 3'd0) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 0", COUNT);
    end
  endtask

  task automatic test_reset_mid();
    RD_READY = 1'b0;
    send(8'h31);
    send(8'h32);
    REQ_IN  = 1'b1;
    ADDR_IN = 8'h33;
    DATA_IN = msg_data(8'h33);
    step();
    total++;
    if ({ACK_OUT, COUNT} !== {1'b1, 3'd3}) begin
      bad++;
      $display("FAIL pre_reset: ack=%b count=%0d want 1 3", ACK_OUT, COUNT);
    end
    #2 RESET = 1'b0;
    #1;
    total++;
    if ({ACK_OUT, RD_VALID, COUNT} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: ack=%b valid=%b count=%0d want 0 0 0", ACK_OUT, RD_VALID, COUNT);
    end
    RESET = 1'b1;
    step();
    total++;
    if ({ACK_OUT, COUNT, RD_ADDR, RD_DATA} !== {1'b1, 3'd1, 8'h33, msg_data(8'h33)}) begin
      bad++;
      $display("FAIL post_reset_req: ack=%b count=%0d addr=%h data=%h want 1 1 33 %h",
               ACK_OUT, COUNT, RD_ADDR, RD_DATA, msg_data(8'h33));
    end
    REQ_IN   = 1'b0;
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
  endtask

`ifdef ULPB_RX_DROP_EN
  task automatic test_drop();
    RD_READY = 1'b0;
    for (int k = 1; k <= 4; k++) send(k);
    for (int k = 0; k < 300; k++) send(8'h80 + (k % 64));
    total++;
    if ({DROP_CNT, COUNT} !== {8'd255, 3'd4}) begin
      bad++;
      $display("FAIL drop_saturate: drop=%0d count=%0d want 255 4", DROP_CNT, COUNT);
    end
    RD_READY = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if ({RD_ADDR, RD_DATA} !== {8'(k), msg_data(k)}) begin
        bad++;
        $display("FAIL drop_contents %0d: addr=%h data=%h", k, RD_ADDR, RD_DATA);
      end
      step();
    end
    RD_READY = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
`ifndef ULPB_RX_DROP_EN
    test_full_backpressure();
`endif
    test_back_to_back();
    test_reset_mid();
`ifdef ULPB_RX_DROP_EN
    test_drop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
